// File: rtl/fa_bist.sv
// Built-in self-test engine for 1-bit full adders: walks all eight {ci,a,b} vectors,
// compares every instance against the golden sum/carry and reports the verdict.
module fa_bist #(
    parameter int unsigned N_DUT      = 3,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ci,
    output logic             a,
    output logic             b,
    input  logic [N_DUT-1:0] s_in,
    input  logic [N_DUT-1:0] co_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       err_cnt,
    output logic [N_DUT-1:0] fail_mask,
    output logic [2:0]       first_fail_vec,
    output logic             first_fail_valid
);

    typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

    // With no settle time a vector goes straight to its check cycle.
    localparam state_e WaitSt = (SETTLE_CYC == 0) ? StCheck : StSettle;
    localparam logic [3:0] SettleLast = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);

    state_e           state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [3:0]       err_q, err_d;
    logic [N_DUT-1:0] mask_q, mask_d;
    logic [2:0]       ffvec_q, ffvec_d;
    logic             ffv_q, ffv_d;

    logic             s_exp;
    logic             co_exp;
    logic [N_DUT-1:0] mism;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        mask_d  = mask_q;
        ffvec_d = ffvec_q;
        ffv_d   = ffv_q;

        s_exp  = vec_q[2] ^ vec_q[1] ^ vec_q[0];
        co_exp = (vec_q[1] & vec_q[0]) | (vec_q[1] & vec_q[2]) | (vec_q[0] & vec_q[2]);
        mism   = (s_in ^ {N_DUT{s_exp}}) | (co_in ^ {N_DUT{co_exp}});

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    vec_d   = 3'd0;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = 4'd0;
                    mask_d  = '0;
                    ffvec_d = 3'd0;
                    ffv_d   = 1'b0;
                    state_d = WaitSt;
                end
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StCheck: begin
                if (|mism) begin
                    err_d  = err_q + 4'd1;
                    mask_d = mask_q | mism;
                    if (!ffv_q) begin
                        ffvec_d = vec_q;
                        ffv_d   = 1'b1;
                    end
                end
                if (vec_q == 3'b111) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_q == 4'd0) && !(|mism);
                end else begin
                    vec_d   = vec_q + 3'd1;
                    cnt_d   = 4'd0;
                    state_d = WaitSt;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vec_q   <= 3'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 4'd0;
            mask_q  <= '0;
            ffvec_q <= 3'd0;
            ffv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            ffvec_q <= ffvec_d;
            ffv_q   <= ffv_d;
        end
    end

    assign ci               = vec_q[2];
    assign a                = vec_q[1];
    assign b                = vec_q[0];
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_cnt          = err_q;
    assign fail_mask        = mask_q;
    assign first_fail_vec   = ffvec_q;
    assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_fa_bist.sv
// Bench for fa_bist: emulated adder instances with injectable per-vector faults,
// results compared against a truth-table model of the expected verdict.
module tb_fa_bist;

    localparam int N = 3;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic ci, a, b;
    logic [N-1:0] s_in, co_in, fail_mask;
    logic busy, done, pass, ffv;
    logic [3:0] err_cnt;
    logic [2:0] ffvec;

    // Zero-settle instance with two fault-free adders.
    logic start_z;
    logic ciz, az, bz;
    logic [1:0] s_z, co_z, mask_z;
    logic busy_z, done_z, pass_z, ffv_z;
    logic [3:0] err_z;
    logic [2:0] ffvec_z;

    // Bit v of flt_s[i]/flt_co[i] flips instance i's sum/carry when vector v is applied.
    logic [7:0] flt_s [N];
    logic [7:0] flt_co[N];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            s_in[i]  = ($countones({ci, a, b}) % 2 == 1) ^ flt_s[i][{ci, a, b}];
            co_in[i] = ($countones({ci, a, b}) >= 2) ^ flt_co[i][{ci, a, b}];
        end
        s_z  = {2{$countones({ciz, az, bz}) % 2 == 1}};
        co_z = {2{$countones({ciz, az, bz}) >= 2}};
    end

    fa_bist #(.N_DUT(N), .SETTLE_CYC(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ci(ci), .a(a), .b(b), .s_in(s_in), .co_in(co_in),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .fail_mask(fail_mask), .first_fail_vec(ffvec), .first_fail_valid(ffv)
    );

    fa_bist #(.N_DUT(2), .SETTLE_CYC(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .start(start_z),
        .ci(ciz), .a(az), .b(bz), .s_in(s_z), .co_in(co_z),
        .busy(busy_z), .done(done_z), .pass(pass_z), .err_cnt(err_z),
        .fail_mask(mask_z), .first_fail_vec(ffvec_z), .first_fail_valid(ffv_z)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < N; i++) begin
            flt_s[i]  = 8'h00;
            flt_co[i] = 8'h00;
        end
    endtask

    // Full run; a start pulse is re-issued at cycle pulse_at (<0: none) and must be ignored.
    task automatic do_run(input int pulse_at);
        int         k;
        int         e_err;
        logic [N-1:0] e_mask;
        logic [2:0] e_first;
        logic       e_fv;
        logic       bad;
        e_err = 0; e_mask = '0; e_first = 3'd0; e_fv = 1'b0;
        for (int v = 0; v < 8; v++) begin
            bad = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (flt_s[i][v] || flt_co[i][v]) begin
                    bad = 1'b1;
                    e_mask[i] = 1'b1;
                end
            end
            if (bad) begin
                e_err++;
                if (!e_fv) begin
                    e_fv = 1'b1;
                    e_first = 3'(v);
                end
            end
        end

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_done_clr", 32'(done), 0);
        chk("start_err_clr", 32'(err_cnt), 0);
        chk("start_mask_clr", 32'(fail_mask), 0);
        chk("start_ffv_clr", 32'(ffv), 0);
        k = 0;
        while (!done && k < 200) begin
            chk("vector_seq", 32'({ci, a, b}), 32'(k / (S + 1)));
            @(negedge clk);
            k++;
            start = (k == pulse_at);
        end
        start = 1'b0;
        chk("done_latency", 32'(k), 32'(8 * (S + 1)));
        chk("busy_low", 32'(busy), 0);
        chk("pass", 32'(pass), 32'(e_err == 0));
        chk("err_cnt", 32'(err_cnt), 32'(e_err));
        chk("fail_mask", 32'(fail_mask), 32'(e_mask));
        chk("first_valid", 32'(ffv), 32'(e_fv));
        chk("first_vec", 32'(ffvec), 32'(e_first));
        repeat (3) @(negedge clk);
        chk("done_hold", 32'(done), 1);
        chk("err_hold", 32'(err_cnt), 32'(e_err));
        chk("vec_hold", 32'({ci, a, b}), 32'd7);
    endtask

    initial begin
        int k;
        start = 1'b0;
        start_z = 1'b0;
        clear_faults();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_vec", 32'({ci, a, b}), 0);
        chk("rst_err", 32'(err_cnt), 0);
        chk("rst_ffv", 32'(ffv), 0);
        @(negedge clk) rst_n = 1'b1;

        // Clean adders, with a start pulse at cycle 10 that must be ignored.
        do_run(10);

        // Instance 1 carry stuck at 0: faults exactly where golden carry is 1.
        clear_faults();
        flt_co[1] = 8'b1110_1000;
        do_run(-1);

        // Instances 0 and 2 have inverted sum.
        clear_faults();
        flt_s[0] = 8'hFF;
        flt_s[2] = 8'hFF;
        do_run(-1);

        // Random sparse faults.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                flt_s[i]  = 8'($urandom & $urandom & $urandom);
                flt_co[i] = 8'($urandom & $urandom & $urandom);
            end
            do_run(-1);
        end

        // Asynchronous reset while vector 100 is applied.
        clear_faults();
        flt_s[0] = 8'hFF;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 0;
        while ({ci, a, b} != 3'b100 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("reach_vec4", 32'({ci, a, b}), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_vec", 32'({ci, a, b}), 0);
        chk("arst_err", 32'(err_cnt), 0);
        chk("arst_mask", 32'(fail_mask), 0);
        chk("arst_ffv", 32'(ffv), 0);
        chk("arst_done", 32'(done), 0);
        @(negedge clk) rst_n = 1'b1;
        clear_faults();
        do_run(-1);

        // Zero settle time: one cycle per vector.
        @(negedge clk) start_z = 1'b1;
        @(negedge clk) start_z = 1'b0;
        k = 0;
        while (!done_z && k < 100) begin
            chk("z_vector_seq", 32'({ciz, az, bz}), 32'(k));
            @(negedge clk);
            k++;
        end
        chk("z_done_latency", 32'(k), 8);
        chk("z_busy", 32'(busy_z), 0);
        chk("z_pass", 32'(pass_z), 1);
        chk("z_err", 32'(err_z), 0);
        chk("z_mask", 32'(mask_z), 0);
        chk("z_ffv", 32'({ffv_z, ffvec_z}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
